// File: rtl/multdiv_scheduler.sv
// Issue/hazard/writeback sequencer for the shared multi-cycle multiply/divide unit.
// Define MULTDIV_SCHED_PERF_EN to add the stall_cycles/op_count performance counters.
module multdiv_scheduler #(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  fd_rs1,
  input  logic [4:0]  fd_rs2,
  input  logic [4:0]  fd_rd,
  output logic        unit_ctrl_mult,
  output logic        unit_ctrl_div,
  input  logic        unit_result_rdy,
  input  logic        unit_exception,
  input  logic [31:0] unit_result,
  output logic        wb_req,
  input  logic        wb_grant,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        stall,
  output logic        busy
`ifdef MULTDIV_SCHED_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] op_count
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_CYCLES - 1);
  localparam logic [4:0]       RSTATUS  = 5'd30;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [4:0]       pend_rd;
  logic             pend_is_div;

  logic accept;
  logic timeout;
  logic pend_hit;
  logic rstatus_hit;
  logic issue_hit;

  // Exception/timeout code written to rstatus: 1 for multiply, 2 for divide.
  function automatic logic [31:0] exc_code(input logic is_div);
    return is_div ? 32'd2 : 32'd1;
  endfunction

  assign accept  = issue_valid && ((state == IDLE) || ((state == WB) && wb_grant));
  assign timeout = (counter == LAST_CNT);
  assign busy    = (state != IDLE);

  assign pend_hit    = (pend_rd != 5'd0) &&
                       ((pend_rd == fd_rs1) || (pend_rd == fd_rs2) || (pend_rd == fd_rd));
  assign rstatus_hit = (wb_rd == RSTATUS) &&
                       ((fd_rs1 == RSTATUS) || (fd_rs2 == RSTATUS) || (fd_rd == RSTATUS));
  assign issue_hit   = (issue_rd != 5'd0) &&
                       ((issue_rd == fd_rs1) || (issue_rd == fd_rs2) || (issue_rd == fd_rd));

  assign stall = (busy && pend_hit) ||
                 (busy && rstatus_hit) ||
                 (issue_valid && (state == BUSY)) ||
                 (issue_valid && issue_hit) ||
                 (issue_valid && (state == WB) && !wb_grant);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      counter        <= '0;
      pend_rd        <= 5'd0;
      pend_is_div    <= 1'b0;
      wb_rd          <= 5'd0;
      wb_data        <= 32'd0;
      unit_ctrl_mult <= 1'b0;
      unit_ctrl_div  <= 1'b0;
      wb_req         <= 1'b0;
    end else begin
      unit_ctrl_mult <= 1'b0;
      unit_ctrl_div  <= 1'b0;
      if (accept) begin
        // Start pulse is registered, so it appears on the first BUSY cycle.
        pend_rd        <= issue_rd;
        pend_is_div    <= issue_is_div;
        unit_ctrl_div  <= issue_is_div;
        unit_ctrl_mult <= !issue_is_div;
        counter        <= '0;
        wb_req         <= 1'b0;
        state          <= BUSY;
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          BUSY: begin
            counter <= counter + 1'b1;
            if (unit_result_rdy && !unit_exception) begin
              wb_rd   <= pend_rd;
              wb_data <= unit_result;
              if (pend_rd == 5'd0) begin
                state <= IDLE;
              end else begin
                wb_req <= 1'b1;
                state  <= WB;
              end
            end else if (unit_result_rdy || timeout) begin
              // A result arriving on the timeout cycle takes priority over the timeout.
              wb_rd   <= RSTATUS;
              wb_data <= exc_code(pend_is_div);
              wb_req  <= 1'b1;
              state   <= WB;
            end
          end
          WB: begin
            if (wb_grant) begin
              wb_req <= 1'b0;
              state  <= IDLE;
            end
          end
          default: begin
            wb_req <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef MULTDIV_SCHED_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
    return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= 32'd0;
      op_count     <= 32'd0;
    end else begin
      stall_cycles <= sat_inc(stall_cycles, stall);
      op_count     <= sat_inc(op_count, accept);
    end
  end
`endif

endmodule

// File: doc/multdiv_scheduler.md
Name: multdiv_scheduler

Overview:
Sequences the shared multi-cycle multiply/divide unit for the pipeline. Accepts one mult/div op at a time from the execute stage and pulses the unit's start controls. Tracks the pending destination register, raises the pipeline stall for RAW and structural hazards, and arbitrates the result into the regfile write port through a req/grant handshake. Exceptions and timeouts are redirected to rstatus (r30).

Parameters:
MAX_CYCLES, 40, cycles in BUSY without unit_result_rdy before a timeout exception is forced
CNT_W, 6, cycle counter width; must satisfy 2^CNT_W > MAX_CYCLES

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
issue_valid  in  1  execute stage holds a mult/div op this cycle
issue_is_div  in  1  1 = div, 0 = mult
issue_rd  in  5  destination register of the issued op
fd_rs1  in  5  F/D-stage source register 1
fd_rs2  in  5  F/D-stage source register 2
fd_rd  in  5  F/D-stage rd (read by sw/branch-style instructions)
unit_ctrl_mult  out  1  one-cycle start pulse to the unit, multiply
unit_ctrl_div  out  1  one-cycle start pulse to the unit, divide
unit_result_rdy  in  1  unit result valid, single cycle
unit_exception  in  1  unit exception, qualified by unit_result_rdy
unit_result  in  32  unit result, qualified by unit_result_rdy
wb_req  out  1  writeback request to the regfile port arbiter
wb_grant  in  1  arbiter grant; write occurs on the cycle of req&grant
wb_rd  out  5  writeback register
wb_data  out  32  writeback data
stall  out  1  freeze F/D and earlier stages this cycle
busy  out  1  state != IDLE

Behaviour:
- Clocking: single clock; all state updates on the rising edge of clock. Reset is synchronous and active-high.
- Reset: state=IDLE; counter, pend_rd, pend_is_div, wb_rd and wb_data = 0; unit_ctrl_mult, unit_ctrl_div, wb_req = 0. Reset mid-operation abandons the op. The unit is not cancelled; any later unit_result_rdy seen in IDLE is ignored.
- States: IDLE, BUSY, WB.
- IDLE:
  - On issue_valid, latch pend_rd=issue_rd and pend_is_div=issue_is_div.
  - Next cycle, drive unit_ctrl_div (div) or unit_ctrl_mult (mult) high for exactly 1 cycle, registered.
  - Go to BUSY with counter=0.
- BUSY:
  - counter increments each cycle. unit_result_rdy is honoured from the first BUSY cycle (the pulse cycle) onward.
  - On unit_result_rdy with unit_exception=0: wb_rd=pend_rd, wb_data=unit_result.
  - On unit_result_rdy with unit_exception=1: wb_rd=30, wb_data=1 for mult or 2 for div.
  - Timeout: counter==MAX_CYCLES-1 with no unit_result_rdy is treated as an exception with the same encoding. A rdy arriving on that same cycle wins over the timeout.
  - If unit_result_rdy && unit_exception==0 && pend_rd==0, go to IDLE with no writeback.
  - Otherwise go to WB.
- WB:
  - wb_req=1, with wb_rd and wb_data held stable until wb_grant.
  - On wb_req&wb_grant: if issue_valid is high the same cycle, accept the new op as in IDLE (pulse next cycle, BUSY); else go to IDLE. wb_req drops the cycle after grant.
- stall (combinational) = any of:
  - (a) state!=IDLE && pend_rd!=0 && pend_rd matches fd_rs1, fd_rs2 or fd_rd.
  - (b) state!=IDLE && wb_rd==30 && any fd register ==30.
  - (c) issue_valid && state==BUSY (structural).
  - (d) issue_valid && issue_rd!=0 && issue_rd matches any fd register (same-cycle issue hazard).
  - (e) issue_valid && state==WB && !wb_grant.
  - Register 0 never causes a RAW stall.
- The execute stage must hold issue_valid and the op stable while stall is high. The scheduler accepts an op only in IDLE, or in WB on grant.
- unit_result_rdy outside BUSY is ignored.

Optional Feature:
MULTDIV_SCHED_PERF_EN
- Defined: adds output ports stall_cycles[31:0] and op_count[31:0].
  - stall_cycles increments each cycle stall=1.
  - op_count increments on each accepted issue.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Mult, rd=5, unit rdy 3 cycles after the pulse, result 0x0000002A, wb_grant immediate -> unit_ctrl_mult high exactly 1 cycle; wb_req with wb_rd=5, wb_data=0x2A; busy low the cycle after grant.
- Pending mult rd=7, fd_rs2=7 -> stall=1 through BUSY and WB until grant; fd_rs1=0 with pend_rd=0 -> stall=0.
- Div, rd=3, unit_result_rdy with unit_exception=1 -> wb_rd=30, wb_data=2; fd_rs1=30 stalls until grant.
- No rdy for MAX_CYCLES=40 cycles on a mult -> WB at cycle 39 with wb_rd=30, wb_data=1.
- wb_grant withheld 4 cycles, new issue_valid held -> wb_req stays high and data stable; stall=1 for those 4 cycles; new op accepted on the grant cycle and its pulse seen next cycle.
- reset asserted in BUSY, then unit_result_rdy -> state IDLE, no wb_req, all outputs 0; with PERF_EN, counters read 0.
